// File: rtl/uhci_pkg.sv
// Shared UHCI definitions: status bit positions, default fatal mask and the
// run/stop controller state encoding.
package uhci_pkg;

    localparam int STS_USBINT    = 0;
    localparam int STS_USBERRINT = 1;
    localparam int STS_RESUME    = 2;
    localparam int STS_HSE       = 3;
    localparam int STS_HCPE      = 4;

    // HostSystemError and HCProcessError stop the schedule.
    localparam logic [4:0] DEFAULT_FATAL_MASK = 5'b11000;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/uhci_w1c_reg.sv
// Vector of write-1-to-clear status bits; a set in the same cycle as a clear
// wins so no event is ever lost. d exposes the next-state value.
module uhci_w1c_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] set,
    input  logic         clr_en,
    input  logic [W-1:0] clr,
    output logic [W-1:0] q,
    output logic [W-1:0] d
);

    logic [W-1:0] clr_mask;

    assign clr_mask = clr_en ? clr : '0;
    assign d        = (q & ~clr_mask) | set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/uhci_status_ctrl.sv
// UHCI Run/Stop and USBSTS controller: latches W1C status, drives the IRQ,
// and sequences RUN -> STOPPING -> HALTED with an idle handshake or timeout.
module uhci_status_ctrl
    import uhci_pkg::*;
#(
    parameter int               N_EVT      = 5,
    parameter logic [N_EVT-1:0] FATAL_MASK = N_EVT'(DEFAULT_FATAL_MASK),
    parameter int               STOP_TMO   = 1024,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EVT-1:0] evt_i,
    input  logic             sts_wr_i,
    input  logic [N_EVT-1:0] sts_wdata_i,
    input  logic [N_EVT-1:0] ien_i,
    input  logic             rs_wr_i,
    input  logic             rs_wdata_i,
    input  logic             hc_idle_i,
    input  logic             cnt_clr_i,
    output logic             rs_o,
    output logic             hchalted_o,
    output logic [N_EVT-1:0] sts_o,
    output logic             irq_o,
    output logic             halt_pulse_o,
    output logic             stop_tmo_o,
    output logic [CNT_W-1:0] fatal_cnt_o,
    output logic [1:0]       state_dbg_o
);

    localparam int TMO_W = (STOP_TMO > 2) ? $clog2(STOP_TMO) : 1;

    state_t           state, state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [N_EVT-1:0] sts_next;
    logic             fatal;
    logic             fatal_latched;
    logic             start_run;
    logic             tmo_halt;

    uhci_w1c_reg #(.W(N_EVT)) u_sts (
        .clk    (clk),
        .rst    (rst),
        .set    (evt_i),
        .clr_en (sts_wr_i),
        .clr    (sts_wdata_i),
        .q      (sts_o),
        .d      (sts_next)
    );

    assign fatal         = |(evt_i & FATAL_MASK);
    assign fatal_latched = |(sts_o & FATAL_MASK);
    assign rs_o          = (state == ST_RUN);
    assign hchalted_o    = (state == ST_HALTED);
    assign state_dbg_o   = state;

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        tmo_halt   = 1'b0;
        case (state)
            ST_HALTED: begin
                if (rs_wr_i && rs_wdata_i && !fatal_latched && !fatal) begin
                    state_next = ST_RUN;
                    start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (fatal || (rs_wr_i && !rs_wdata_i)) state_next = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (hc_idle_i) begin
                    state_next = ST_HALTED;
                end else if (tmo_cnt == TMO_W'(STOP_TMO - 1)) begin
                    state_next = ST_HALTED;
                    tmo_halt   = 1'b1;
                end
            end
            default: state_next = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_HALTED;
            tmo_cnt      <= '0;
            irq_o        <= 1'b0;
            halt_pulse_o <= 1'b0;
            stop_tmo_o   <= 1'b0;
            fatal_cnt_o  <= '0;
        end else begin
            state        <= state_next;
            irq_o        <= |(sts_next & ien_i);
            halt_pulse_o <= (state_next == ST_HALTED) && (state != ST_HALTED);
            // Counter only runs while staying in STOPPING; entry loads zero.
            if (state == ST_STOPPING && state_next == ST_STOPPING) tmo_cnt <= tmo_cnt + 1'b1;
            else                                                    tmo_cnt <= '0;
            if (start_run)     stop_tmo_o <= 1'b0;
            else if (tmo_halt) stop_tmo_o <= 1'b1;
            if (cnt_clr_i)                         fatal_cnt_o <= '0;
            else if (fatal && fatal_cnt_o != '1)   fatal_cnt_o <= fatal_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_uhci_status_ctrl.sv
// Directed bench for uhci_status_ctrl: vector table plus hand-written timeout
// and async-reset sequences.
module tb_uhci_status_ctrl;
    import uhci_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] evt;
    logic       sts_wr;
    logic [4:0] sts_wdata;
    logic [4:0] ien;
    logic       rs_wr;
    logic       rs_wdata;
    logic       hc_idle;
    logic       cnt_clr;
    logic       rs;
    logic       hchalted;
    logic [4:0] sts;
    logic       irq;
    logic       halt_pulse;
    logic       stop_tmo;
    logic [1:0] fatal_cnt;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] evt;
        logic       sts_wr;
        logic [4:0] wdata;
        logic [4:0] ien;
        logic       rs_wr;
        logic       rs_wd;
        logic       idle;
        logic       cclr;
        logic       e_rs;
        logic       e_hch;
        logic [4:0] e_sts;
        logic       e_irq;
        logic       e_hp;
        logic       e_tmo;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[24];

    uhci_status_ctrl #(
        .N_EVT      (5),
        .FATAL_MASK (5'b11000),
        .STOP_TMO   (16),
        .CNT_W      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .evt_i        (evt),
        .sts_wr_i     (sts_wr),
        .sts_wdata_i  (sts_wdata),
        .ien_i        (ien),
        .rs_wr_i      (rs_wr),
        .rs_wdata_i   (rs_wdata),
        .hc_idle_i    (hc_idle),
        .cnt_clr_i    (cnt_clr),
        .rs_o         (rs),
        .hchalted_o   (hchalted),
        .sts_o        (sts),
        .irq_o        (irq),
        .halt_pulse_o (halt_pulse),
        .stop_tmo_o   (stop_tmo),
        .fatal_cnt_o  (fatal_cnt),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        evt = '0; sts_wr = 0; sts_wdata = '0; ien = '0;
        rs_wr = 0; rs_wdata = 0; hc_idle = 1; cnt_clr = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rs"},    32'(rs), 32'd0);
        check({tag, "_hch"},   32'(hchalted), 32'd1);
        check({tag, "_sts"},   32'(sts), 32'd0);
        check({tag, "_irq"},   32'(irq), 32'd0);
        check({tag, "_hp"},    32'(halt_pulse), 32'd0);
        check({tag, "_tmo"},   32'(stop_tmo), 32'd0);
        check({tag, "_cnt"},   32'(fatal_cnt), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_HALTED));
    endtask

    function automatic vec_t mk(input logic [4:0] e, input logic sw, input logic [4:0] wd,
                                input logic [4:0] ie, input logic rw, input logic rd,
                                input logic id, input logic cc, input logic x_rs,
                                input logic x_hch, input logic [4:0] x_sts, input logic x_irq,
                                input logic x_hp, input logic x_tmo, input logic [1:0] x_cnt);
        vec_t v;
        v.evt = e; v.sts_wr = sw; v.wdata = wd; v.ien = ie; v.rs_wr = rw; v.rs_wd = rd;
        v.idle = id; v.cclr = cc; v.e_rs = x_rs; v.e_hch = x_hch; v.e_sts = x_sts;
        v.e_irq = x_irq; v.e_hp = x_hp; v.e_tmo = x_tmo; v.e_cnt = x_cnt;
        return v;
    endfunction

    initial begin
        //            evt      wr wdata    ien      rw rd id cc | rs hch sts     irq hp tmo cnt
        vecs[0]  = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  1, 0, 5'h00,   0, 0, 0, 2'd0);
        vecs[1]  = mk(5'h00,   0, 5'h00,   5'h00,   0, 0, 1, 0,  1, 0, 5'h00,   0, 0, 0, 2'd0);
        vecs[2]  = mk(5'h00,   0, 5'h00,   5'h00,   1, 0, 1, 0,  0, 0, 5'h00,   0, 0, 0, 2'd0);
        vecs[3]  = mk(5'h00,   0, 5'h00,   5'h00,   0, 0, 1, 0,  0, 1, 5'h00,   0, 1, 0, 2'd0);
        vecs[4]  = mk(5'h00,   0, 5'h00,   5'h00,   0, 0, 1, 0,  0, 1, 5'h00,   0, 0, 0, 2'd0);
        vecs[5]  = mk(5'h01,   1, 5'h01,   5'h01,   0, 0, 1, 0,  0, 1, 5'h01,   1, 0, 0, 2'd0);
        vecs[6]  = mk(5'h00,   1, 5'h01,   5'h01,   0, 0, 1, 0,  0, 1, 5'h00,   0, 0, 0, 2'd0);
        vecs[7]  = mk(5'h04,   0, 5'h00,   5'h00,   0, 0, 1, 0,  0, 1, 5'h04,   0, 0, 0, 2'd0);
        vecs[8]  = mk(5'h00,   0, 5'h00,   5'h04,   0, 0, 1, 0,  0, 1, 5'h04,   1, 0, 0, 2'd0);
        vecs[9]  = mk(5'h00,   1, 5'h04,   5'h04,   0, 0, 1, 0,  0, 1, 5'h00,   0, 0, 0, 2'd0);
        vecs[10] = mk(5'h08,   0, 5'h00,   5'h00,   1, 1, 1, 0,  0, 1, 5'h08,   0, 0, 0, 2'd1);
        vecs[11] = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  0, 1, 5'h08,   0, 0, 0, 2'd1);
        vecs[12] = mk(5'h00,   1, 5'h08,   5'h00,   0, 0, 1, 0,  0, 1, 5'h00,   0, 0, 0, 2'd1);
        vecs[13] = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  1, 0, 5'h00,   0, 0, 0, 2'd1);
        vecs[14] = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  1, 0, 5'h00,   0, 0, 0, 2'd1);
        vecs[15] = mk(5'h10,   0, 5'h00,   5'h00,   0, 0, 0, 0,  0, 0, 5'h10,   0, 0, 0, 2'd2);
        vecs[16] = mk(5'h10,   0, 5'h00,   5'h00,   0, 0, 0, 0,  0, 0, 5'h10,   0, 0, 0, 2'd3);
        vecs[17] = mk(5'h10,   0, 5'h00,   5'h00,   1, 1, 0, 0,  0, 0, 5'h10,   0, 0, 0, 2'd3);
        vecs[18] = mk(5'h00,   0, 5'h00,   5'h00,   0, 0, 0, 0,  0, 0, 5'h10,   0, 0, 0, 2'd3);
        vecs[19] = mk(5'h00,   0, 5'h00,   5'h00,   0, 0, 1, 0,  0, 1, 5'h10,   0, 1, 0, 2'd3);
        vecs[20] = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  0, 1, 5'h10,   0, 0, 0, 2'd3);
        vecs[21] = mk(5'h08,   1, 5'h10,   5'h00,   0, 0, 1, 1,  0, 1, 5'h08,   0, 0, 0, 2'd0);
        vecs[22] = mk(5'h00,   1, 5'h08,   5'h00,   0, 0, 1, 0,  0, 1, 5'h00,   0, 0, 0, 2'd0);
        vecs[23] = mk(5'h00,   0, 5'h00,   5'h00,   1, 1, 1, 0,  1, 0, 5'h00,   0, 0, 0, 2'd0);

        rst = 1'b1;
        idle_inputs();
        #12;
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            evt = vecs[i].evt; sts_wr = vecs[i].sts_wr; sts_wdata = vecs[i].wdata;
            ien = vecs[i].ien; rs_wr = vecs[i].rs_wr; rs_wdata = vecs[i].rs_wd;
            hc_idle = vecs[i].idle; cnt_clr = vecs[i].cclr;
            tick();
            check($sformatf("v%0d_rs", i),  32'(rs), 32'(vecs[i].e_rs));
            check($sformatf("v%0d_hch", i), 32'(hchalted), 32'(vecs[i].e_hch));
            check($sformatf("v%0d_sts", i), 32'(sts), 32'(vecs[i].e_sts));
            check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
            check($sformatf("v%0d_hp", i),  32'(halt_pulse), 32'(vecs[i].e_hp));
            check($sformatf("v%0d_tmo", i), 32'(stop_tmo), 32'(vecs[i].e_tmo));
            check($sformatf("v%0d_cnt", i), 32'(fatal_cnt), 32'(vecs[i].e_cnt));
        end

        // Stop with the schedule never going idle: 16 cycles in STOPPING, then forced halt.
        idle_inputs();
        hc_idle = 0; rs_wr = 1; rs_wdata = 0;
        tick();
        rs_wr = 0;
        check("tmo_enter_rs", 32'(rs), 32'd0);
        check("tmo_enter_state", 32'(state_dbg), 32'(ST_STOPPING));
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("tmo_wait%0d_hch", k), 32'(hchalted), 32'd0);
            check($sformatf("tmo_wait%0d_hp", k),  32'(halt_pulse), 32'd0);
        end
        tick();
        check("tmo_halt_hch", 32'(hchalted), 32'd1);
        check("tmo_halt_hp",  32'(halt_pulse), 32'd1);
        check("tmo_halt_flag", 32'(stop_tmo), 32'd1);
        tick();
        check("tmo_after_hp",   32'(halt_pulse), 32'd0);
        check("tmo_after_flag", 32'(stop_tmo), 32'd1);
        rs_wr = 1; rs_wdata = 1;
        tick();
        rs_wr = 0;
        check("tmo_restart_rs",   32'(rs), 32'd1);
        check("tmo_restart_flag", 32'(stop_tmo), 32'd0);

        // Fatal stop with pending irq, then reset asserted mid-cycle in STOPPING.
        evt = 5'h10; ien = 5'h10;
        tick();
        evt = '0;
        check("prerst_state", 32'(state_dbg), 32'(ST_STOPPING));
        check("prerst_irq",   32'(irq), 32'd1);
        check("prerst_cnt",   32'(fatal_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uhci_status_ctrl.md
Name: uhci_status_ctrl

Overview:
- Parametrised run/stop and status-error controller for the UHCI host controller.
- Latches N_EVT event/error sources into USBSTS-style write-1-to-clear bits and raises the interrupt line through a per-bit enable mask.
- Owns the Run/Stop (RS) bit: fatal events clear it, and HCHalted asserts only after the schedule FSM reports idle, or after a stop timeout.
- Sits between the schedule/transaction FSM and the register file.

Parameters:
- N_EVT, 5, number of latched status bits (bit0 USBINT, bit1 USBERRINT, bit2 ResumeDetect, bit3 HostSystemError, bit4 HCProcessError).
- FATAL_MASK, 5'b11000, status bits whose assertion forces RS=0.
- STOP_TMO, 1024, cycles allowed in STOPPING before a forced halt; must be ≥2.
- CNT_W, 8, width of the saturating fatal-event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- evt_i  in  N_EVT  event pulses from FSM/bus logic, one bit per status bit, level-sampled each cycle
- sts_wr_i  in  1  software write strobe to status register
- sts_wdata_i  in  N_EVT  W1C data: 1 clears the corresponding bit
- ien_i  in  N_EVT  interrupt enable mask from register file
- rs_wr_i  in  1  software write strobe to RS
- rs_wdata_i  in  1  RS value written
- hc_idle_i  in  1  schedule FSM has no transaction in flight
- cnt_clr_i  in  1  synchronous clear of fatal counter
- rs_o  out  1  Run/Stop bit
- hchalted_o  out  1  HCHalted status
- sts_o  out  N_EVT  latched status bits
- irq_o  out  1  interrupt request
- halt_pulse_o  out  1  one-cycle pulse on entry to HALTED
- stop_tmo_o  out  1  sticky flag: last halt was forced by timeout
- fatal_cnt_o  out  CNT_W  saturating count of fatal events

Behaviour:
- Reset values: rs_o=0, hchalted_o=1, sts_o=0, irq_o=0, halt_pulse_o=0, stop_tmo_o=0, fatal_cnt_o=0, state=HALTED, timeout counter=0. Reset mid-operation returns to these values immediately (async).
- Status bit i, per cycle:
  - evt_i[i]=1 → sets the bit next cycle.
  - sts_wr_i && sts_wdata_i[i] → clears it.
  - Set wins over clear in the same cycle.
- irq_o is registered: next cycle = |(sts_next & ien_i). Latency from evt_i to irq_o is 1 cycle.
- Fatal event: fatal = |(evt_i & FATAL_MASK).
  - fatal_cnt_o increments by 1 per cycle in which fatal=1, saturating at all-ones.
  - cnt_clr_i has priority over increment.
- FSM states and transitions:
  - HALTED:
    - rs_wr_i && rs_wdata_i && no fatal bit set in sts_o && fatal=0 → RUN. Next cycle rs_o=1, hchalted_o=0, stop_tmo_o cleared.
    - The write is ignored otherwise, and rs_o stays 0.
  - RUN:
    - fatal=1, or rs_wr_i && !rs_wdata_i → STOPPING. Next cycle rs_o=0; the timeout counter loads 0.
    - rs_wr_i && rs_wdata_i → no effect.
  - STOPPING:
    - rs_o=0 and hchalted_o=0. The counter increments each cycle.
    - hc_idle_i=1 → HALTED.
    - Otherwise, counter reaching STOP_TMO-1 → HALTED with stop_tmo_o=1.
    - STOPPING lasts at least one cycle even if hc_idle_i is already 1 on entry.
    - RS writes are ignored.
  - Entry to HALTED: hchalted_o=1 and halt_pulse_o=1 for exactly one cycle.
- Simultaneous fatal event and rs set write in HALTED: the write is rejected. The fatal status bit still latches.
- Fatal event while already in STOPPING/HALTED: latches status and counts only; there is no state change.

Decomposition:
- Shared package uhci_pkg:
  - status bit index constants (STS_USBINT=0 … STS_HCPE=4)
  - default FATAL_MASK
  - state enum {HALTED, RUN, STOPPING}
- One natural sub-module, uhci_w1c_reg: a parametrised vector of set-priority W1C bits. It is reused by the port status logic.
- FSM, timeout counter and fatal counter stay in the top.

Test Plan:
- Reset then rs_wr_i=1/rs_wdata_i=1 with hc_idle_i=1 → next cycle rs_o=1, hchalted_o=0; then rs_wdata_i=0 → rs_o=0 next cycle, hchalted_o=1 and halt_pulse_o=1 two cycles after the write.
- In RUN, evt_i=5'b10000 with hc_idle_i=0 for 10 cycles then 1 → rs_o=0 immediately, sts_o[4]=1, fatal_cnt_o=1, hchalted_o=1 one cycle after idle; RS set write rejected until sts_wdata_i=5'b10000 W1C.
- evt_i[0]=1 and sts_wr_i with sts_wdata_i[0]=1 in the same cycle, ien_i=5'b00001 → sts_o[0] remains 1, irq_o=1; W1C alone next → sts_o[0]=0, irq_o=0.
- STOP_TMO=16, stop from RUN with hc_idle_i held 0 → HALTED after 16 cycles in STOPPING, stop_tmo_o=1, halt_pulse_o single cycle.
- CNT_W=2, four fatal pulses → fatal_cnt_o=3 (saturated); cnt_clr_i with a simultaneous fatal → 0.
- Assert rst while in STOPPING → all outputs return to reset values asynchronously; hchalted_o=1, rs_o=0.
